bcd_hex_scan_counter: RTL

Parametrised successor of the free-running hex counter/display top. It holds a DIGITS-nibble counter with runtime-selectable hex or decimal (BCD) counting, up/down direction, enable and synchronous clear. It also contains a multiplexed 7-segment scan driver with optional leading-zero blanking. Everything runs on the single board clock: both rates come from internal tick prescalers (clock enables, no derived clocks). The block sits directly between the board pins and any controller that drives EN/UP/MODE.

---
 rtl/bcd_hex_scan_counter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/bcd_hex_scan_counter.sv
// rtl/bcd_hex_scan_counter.sv - hex/BCD up/down digit counter with multiplexed 7-segment scan driver
module bcd_hex_scan_counter #(
    parameter int DIGITS    = 4,
    parameter int COUNT_DIV = 24,
    parameter int SCAN_DIV  = 16
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  EN,
    input  logic                  UP,
    input  logic                  CLR,
    input  logic                  MODE,
    input  logic                  BLANK_LZ,
    output logic [4*DIGITS-1:0]   VALUE,
    output logic                  WRAP,
    output logic [DIGITS-1:0]     ANODES,
    output logic [6:0]            SEG
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [COUNT_DIV-1:0] cpre_q, cpre_d;
    logic [SCAN_DIV-1:0]  spre_q, spre_d;
    logic [4*DIGITS-1:0]  value_q, value_d;
    logic                 wrap_q, wrap_d;
    logic                 mode_q, mode_d;
    logic                 mode_vld_q, mode_vld_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DIGITS-1:0]    anodes_q, anodes_d;
    logic [6:0]           seg_q, seg_d;

    logic                 count_tick;
    logic                 scan_tick;
    logic [4*DIGITS-1:0]  step_value;
    logic                 step_carry;
    logic [3:0]           digit_max;
    logic [3:0]           dig;
    logic [3:0]           cur_digit;
    logic                 zero_run;
    logic                 sel_zero;
    logic                 blank;

    function automatic logic [6:0] font(input logic [3:0] d);
        case (d)
            4'h0: font = 7'b1111110;
            4'h1: font = 7'b0110000;
            4'h2: font = 7'b1101101;
            4'h3: font = 7'b1111001;
            4'h4: font = 7'b0110011;
            4'h5: font = 7'b1011011;
            4'h6: font = 7'b1011111;
            4'h7: font = 7'b1110000;
            4'h8: font = 7'b1111111;
            4'h9: font = 7'b1111011;
            4'hA: font = 7'b1110111;
            4'hB: font = 7'b0011111;
            4'hC: font = 7'b1001110;
            4'hD: font = 7'b0111101;
            4'hE: font = 7'b1001111;
            default: font = 7'b1000111;
        endcase
    endfunction

    assign count_tick = &cpre_q;
    assign scan_tick  = &spre_q;

    // Ripple carry/borrow through the digits; the carry out of the top digit is the wrap.
    always_comb begin
        digit_max  = MODE ? 4'd9 : 4'd15;
        step_value = value_q;
        step_carry = 1'b1;
        dig        = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            dig = value_q[4*k +: 4];
            if (step_carry) begin
                if (UP) begin
                    if (dig == digit_max) begin
                        step_value[4*k +: 4] = 4'd0;
                    end else begin
                        step_value[4*k +: 4] = dig + 4'd1;
                        step_carry           = 1'b0;
                    end
                end else begin
                    if (dig == 4'd0) begin
                        step_value[4*k +: 4] = digit_max;
                    end else begin
                        step_value[4*k +: 4] = dig - 4'd1;
                        step_carry           = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        cpre_d     = cpre_q + COUNT_DIV'(1);
        spre_d     = spre_q + SCAN_DIV'(1);
        value_d    = value_q;
        wrap_d     = 1'b0;
        mode_d     = MODE;
        mode_vld_d = 1'b1;
        idx_d      = idx_q;

        if (CLR) begin
            value_d = '0;
        end else if (mode_vld_q && (MODE != mode_q)) begin
            value_d = '0;
        end else if (count_tick && EN) begin
            value_d = step_value;
            wrap_d  = step_carry;
        end

        if (scan_tick) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        cur_digit = 4'd0;
        zero_run  = 1'b1;
        sel_zero  = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (value_q[4*k +: 4] == 4'd0);
            if (idx_q == IDX_W'(k)) begin
                cur_digit = value_q[4*k +: 4];
                sel_zero  = zero_run;
            end
        end
        blank = BLANK_LZ && (idx_q != '0) && sel_zero;
        if (blank) begin
            anodes_d = '1;
            seg_d    = 7'b0000000;
        end else begin
            anodes_d = ~(DIGITS'(1) << idx_q);
            seg_d    = font(cur_digit);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cpre_q     <= '0;
            spre_q     <= '0;
            value_q    <= '0;
            wrap_q     <= 1'b0;
            mode_q     <= 1'b0;
            mode_vld_q <= 1'b0;
            idx_q      <= '0;
            anodes_q   <= '1;
            seg_q      <= 7'b0000000;
        end else begin
            cpre_q     <= cpre_d;
            spre_q     <= spre_d;
            value_q    <= value_d;
            wrap_q     <= wrap_d;
            mode_q     <= mode_d;
            mode_vld_q <= mode_vld_d;
            idx_q      <= idx_d;
            anodes_q   <= anodes_d;
            seg_q      <= seg_d;
        end
    end

    assign VALUE  = value_q;
    assign WRAP   = wrap_q;
    assign ANODES = anodes_q;
    assign SEG    = seg_q;

endmodule
